// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the SPI register-write controller.
//   FRAME_W / RW_BIT : serial frame geometry ({rw, addr[6:0], data[7:0]}, MSB first)
//   state_t          : controller state encoding
//   REG_*            : register map of the onboarding SPI peripheral
package spi_pkg;

    localparam int FRAME_W = 16;
    localparam int RW_BIT  = 15;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    localparam logic [6:0] REG_OUT_EN_LO = 7'h00;  // out-enable [7:0]
    localparam logic [6:0] REG_OUT_EN_HI = 7'h01;  // out-enable [15:8]
    localparam logic [6:0] REG_PWM_EN_LO = 7'h02;  // PWM-enable [7:0]
    localparam logic [6:0] REG_PWM_EN_HI = 7'h03;  // PWM-enable [15:8]
    localparam logic [6:0] REG_DUTY      = 7'h04;  // PWM duty cycle

endpackage

// File: rtl/spi_reg_writer_if.sv
// spi_reg_writer_if: bundles the request handshake, status and SPI pins of
// spi_reg_writer.
//   master : the requester side (drives req_*, observes status and pins)
//   slave  : the controller side (consumes req_*, drives status and pins)
interface spi_reg_writer_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic              busy;
    logic              done;
    logic              spi_ncs;
    logic              spi_sclk;
    logic              spi_copi;

    modport master (
        output req_valid, req_write, req_addr, req_data,
        input  req_ready, busy, done, spi_ncs, spi_sclk, spi_copi
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_data,
        output req_ready, busy, done, spi_ncs, spi_sclk, spi_copi
    );
endinterface

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: half-period timer and SCLK flop for the SPI controller.
//   clk, rst   : system clock, async active-high reset
//   run        : timer counts while high; held at reload value otherwise
//   toggle_en  : SCLK may toggle when the current half period expires
//   tick       : last cycle of the current CLK_DIV-cycle interval
//   sclk_rise  : SCLK goes high at the coming edge
//   sclk_fall  : SCLK goes low at the coming edge
//   sclk       : registered SCLK
module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic toggle_en,
    output logic tick,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic sclk
);

    localparam int               CNT_W    = $clog2(CLK_DIV + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sclk_q, sclk_d;

    always_comb begin
        tick      = run && (cnt_q == '0);
        sclk_rise = tick && toggle_en && !sclk_q;
        sclk_fall = tick && toggle_en && sclk_q;

        // Down-counter auto-reloads so consecutive intervals need no restart.
        cnt_d = cnt_q;
        if (!run || cnt_q == '0) begin
            cnt_d = CNT_LOAD;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end

        sclk_d = sclk_q;
        if (!run) begin
            sclk_d = 1'b0;
        end else if (sclk_rise) begin
            sclk_d = 1'b1;
        end else if (sclk_fall) begin
            sclk_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= CNT_LOAD;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk = sclk_q;

endmodule

// File: rtl/spi_reg_writer.sv
// spi_reg_writer: SPI mode-0 initiator issuing 16-bit register-write frames
// {req_write, req_addr, req_data}, MSB first.
//   clk, rst : system clock, async active-high reset
//   bus      : slave modport of spi_reg_writer_if
//              req_valid/req_ready/req_write/req_addr/req_data : request port
//              busy, done                                      : status
//              spi_ncs, spi_sclk, spi_copi                     : SPI pins
// A frame is SETUP (CLK_DIV) + 16 x (CLK_DIV high + CLK_DIV low) + HOLD
// (CLK_DIV) with nCS low, then GAP (CLK_DIV) with nCS high before IDLE.
module spi_reg_writer
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 8
) (
    input  logic            clk,
    input  logic            rst,
    spi_reg_writer_if.slave bus
);

    state_t             state_q, state_d;
    logic [FRAME_W-1:0] sr_q, sr_d, frame;
    logic [3:0]         bit_q, bit_d;   // index of the bit currently on COPI
    logic               ncs_q, ncs_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic tick, sclk_rise, sclk_fall, sclk, run, toggle_en;

    spi_clk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_gen (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .toggle_en(toggle_en),
        .tick     (tick),
        .sclk_rise(sclk_rise),
        .sclk_fall(sclk_fall),
        .sclk     (sclk)
    );

    always_comb begin
        frame                    = '0;
        frame[RW_BIT]            = bus.req_write;
        frame[RW_BIT-1 -: ADDR_W] = bus.req_addr;
        frame[DATA_W-1:0]        = bus.req_data;

        run = (state_q != IDLE);
        // The first rise ends SETUP; in SHIFT the clock stops low after bit 0.
        toggle_en = (state_q == SETUP) ||
                    ((state_q == SHIFT) && (sclk || bit_q != 4'd0));

        state_d = state_q;
        sr_d    = sr_q;
        bit_d   = bit_q;
        ncs_d   = ncs_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.req_valid && ready_q) begin
                    sr_d    = frame;
                    bit_d   = 4'd15;
                    ncs_d   = 1'b0;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (tick) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // COPI moves on the falling edge; bit 0 is held to the end.
                if (sclk_fall && bit_q != 4'd0) begin
                    sr_d = {sr_q[FRAME_W-2:0], 1'b0};
                end
                if (sclk_rise) begin
                    bit_d = bit_q - 4'd1;
                end
                if (tick && !sclk && bit_q == 4'd0) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (tick) begin
                    ncs_d   = 1'b1;
                    done_d  = 1'b1;
                    sr_d    = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (tick) begin
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            bit_q   <= 4'd15;
            ncs_q   <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            bit_q   <= bit_d;
            ncs_q   <= ncs_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.spi_ncs   = ncs_q;
    assign bus.spi_sclk  = sclk;
    assign bus.spi_copi  = sr_q[FRAME_W-1];

endmodule
